// File: rtl/mul_arbiter_if.sv
// Operation encoding and the request/response bundle shared by mul_arbiter and its requesters/consumer.
package mul_arbiter_pkg;
    typedef enum logic [3:0] {
        ALU_ADD    = 4'h0,
        ALU_SUB    = 4'h1,
        ALU_AND    = 4'h2,
        ALU_OR     = 4'h3,
        ALU_MUL    = 4'h8,
        ALU_MULH   = 4'h9,
        ALU_MULHSU = 4'hA,
        ALU_MULHU  = 4'hB
    } alu_t;
endpackage

interface mul_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 5
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    mul_arbiter_pkg::alu_t [NUM_REQ-1:0] req_op;
    logic [NUM_REQ*32-1:0]              req_rs1;
    logic [NUM_REQ*32-1:0]              req_rs2;
    logic [NUM_REQ*TAG_W-1:0]           req_tag;
    logic                               resp_valid;
    logic                               resp_ready;
    logic [31:0]                        resp_data;
    logic [TAG_W-1:0]                   resp_tag;
    logic [SRC_W-1:0]                   resp_src;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag, resp_src
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag, resp_src
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter feeding one shared LAT-deep integer multiplier; results return in accept order.
// Optional flush input enabled by defining MUL_ARB_FLUSH_EN.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int LAT     = 2,
    parameter int TAG_W   = 5
) (
    input  logic         clk,
    input  logic         rst,
`ifdef MUL_ARB_FLUSH_EN
    input  logic         flush,
`endif
    mul_arbiter_if.slave bus
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic flushNow;
`ifdef MUL_ARB_FLUSH_EN
    assign flushNow = flush;
`else
    assign flushNow = 1'b0;
`endif

    logic [SRC_W-1:0] rrPtr_q, rrPtr_d;
    logic [SRC_W-1:0] grantIdx;
    logic [SRC_W-1:0] scanSel;
    int               scanIdx;
    logic             grantFound;
    logic             stall;
    logic             accept;

    logic             lastValid;
    logic [31:0]      lastData;
    logic [TAG_W-1:0] lastTag;
    logic [SRC_W-1:0] lastSrc;

    logic             s1Valid_q;
    alu_t             s1Op_q;
    logic [31:0]      s1Rs1_q, s1Rs2_q;
    logic [TAG_W-1:0] s1Tag_q;
    logic [SRC_W-1:0] s1Src_q;

    logic [63:0]      aExt, bExt, product;
    logic [31:0]      mulResult;

    // Flush wins over a stall: while flushing resp_valid is forced low, so nothing holds.
    assign stall  = lastValid & ~flushNow & ~bus.resp_ready;
    assign accept = grantFound & ~stall & ~flushNow;

    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        scanIdx    = 0;
        scanSel    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx = int'(rrPtr_q) + k;
            if (scanIdx >= NUM_REQ) begin
                scanIdx = scanIdx - NUM_REQ;
            end
            scanSel = SRC_W'(scanIdx);
            if (!grantFound && bus.req_valid[scanSel]) begin
                grantFound = 1'b1;
                grantIdx   = scanSel;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grantIdx] = 1'b1;
        end
    end

    always_comb begin
        rrPtr_d = rrPtr_q;
        if (accept) begin
            rrPtr_d = (int'(grantIdx) == NUM_REQ - 1) ? '0 : grantIdx + SRC_W'(1);
        end
    end

    // Op resets to MUL so that with zero operands the LAT=1 output reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rrPtr_q   <= '0;
            s1Valid_q <= 1'b0;
            s1Op_q    <= ALU_MUL;
            s1Rs1_q   <= '0;
            s1Rs2_q   <= '0;
            s1Tag_q   <= '0;
            s1Src_q   <= '0;
        end else begin
            rrPtr_q <= rrPtr_d;
            if (flushNow) begin
                s1Valid_q <= 1'b0;
            end else if (!stall) begin
                s1Valid_q <= accept;
                if (accept) begin
                    s1Op_q  <= bus.req_op[grantIdx];
                    s1Rs1_q <= bus.req_rs1[32*grantIdx +: 32];
                    s1Rs2_q <= bus.req_rs2[32*grantIdx +: 32];
                    s1Tag_q <= bus.req_tag[TAG_W*grantIdx +: TAG_W];
                    s1Src_q <= grantIdx;
                end
            end
        end
    end

    // One 64-bit multiplier serves all variants; extending each operand per its signedness yields the exact product.
    always_comb begin
        aExt = (s1Op_q == ALU_MULHU) ? {32'b0, s1Rs1_q} : {{32{s1Rs1_q[31]}}, s1Rs1_q};
        bExt = (s1Op_q == ALU_MUL || s1Op_q == ALU_MULH) ? {{32{s1Rs2_q[31]}}, s1Rs2_q}
                                                          : {32'b0, s1Rs2_q};
        product   = aExt * bExt;
        mulResult = 32'hDEADBEEF;
        case (s1Op_q)
            ALU_MUL:                         mulResult = product[31:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: mulResult = product[63:32];
            default:                         mulResult = 32'hDEADBEEF;
        endcase
    end

    generate
        if (LAT == 1) begin : gLat1
            assign lastValid = s1Valid_q;
            assign lastData  = mulResult;
            assign lastTag   = s1Tag_q;
            assign lastSrc   = s1Src_q;
        end else begin : gLatN
            logic [LAT-2:0]   pValid_q;
            logic [31:0]      pData_q [LAT-1];
            logic [TAG_W-1:0] pTag_q  [LAT-1];
            logic [SRC_W-1:0] pSrc_q  [LAT-1];

            // The whole pipe moves as one; bubbles travel with it rather than being squeezed out.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pValid_q <= '0;
                    for (int k = 0; k < LAT - 1; k++) begin
                        pData_q[k] <= '0;
                        pTag_q[k]  <= '0;
                        pSrc_q[k]  <= '0;
                    end
                end else if (flushNow) begin
                    pValid_q <= '0;
                end else if (!stall) begin
                    pValid_q[0] <= s1Valid_q;
                    pData_q[0]  <= mulResult;
                    pTag_q[0]   <= s1Tag_q;
                    pSrc_q[0]   <= s1Src_q;
                    for (int k = 1; k < LAT - 1; k++) begin
                        pValid_q[k] <= pValid_q[k-1];
                        pData_q[k]  <= pData_q[k-1];
                        pTag_q[k]   <= pTag_q[k-1];
                        pSrc_q[k]   <= pSrc_q[k-1];
                    end
                end
            end

            assign lastValid = pValid_q[LAT-2];
            assign lastData  = pData_q[LAT-2];
            assign lastTag   = pTag_q[LAT-2];
            assign lastSrc   = pSrc_q[LAT-2];
        end
    endgenerate

    assign bus.resp_valid = lastValid & ~flushNow;
    assign bus.resp_data  = lastData;
    assign bus.resp_tag   = lastTag;
    assign bus.resp_src   = lastSrc;
endmodule
